// File: rtl/cnn_pkg.sv
// Shared types and constants for the convolution layer engine.
package cnn_pkg;

  localparam int ADDR_SIZE = 19;

  typedef logic [7:0]         byte_t;
  typedef logic signed [31:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } conv_state_t;

endpackage

// File: rtl/conv_layer_engine_if.sv
// Memory-side bus of the convolution engine: two synchronous read ports and one write port.
interface conv_mem_if #(
  parameter int ADDR_SIZE = cnn_pkg::ADDR_SIZE
);

  logic [ADDR_SIZE-1:0] in_addr;
  logic [7:0]           in_data;
  logic [ADDR_SIZE-1:0] w_addr;
  logic signed [7:0]    w_data;
  logic [ADDR_SIZE-1:0] out_addr;
  logic [7:0]           out_data;
  logic                 out_we;

  modport master (
    output in_addr,
    input  in_data,
    output w_addr,
    input  w_data,
    output out_addr,
    output out_data,
    output out_we
  );

  modport slave (
    input  in_addr,
    output in_data,
    input  w_addr,
    output w_data,
    input  out_addr,
    input  out_data,
    input  out_we
  );

endinterface

// File: rtl/conv_mac.sv
// Multiply-accumulate datapath: pixel x weight product, accumulator, and
// shift/ReLU/saturate requantisation into the result byte.
module conv_mac #(
  parameter int SHIFT  = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vld_p0,
  input  logic                     first_p0,
  input  logic                     last_p0,
  input  logic [DATA_W-1:0]        pixel,
  input  logic signed [COEF_W-1:0] weight,
  output logic [7:0]               result
);

  import cnn_pkg::*;

  localparam int PROD_W = DATA_W + 1 + COEF_W;

  function automatic byte_t relu_sat(input acc_t a);
    acc_t r;
    r = a >>> SHIFT;
    if (r < 0)
      return 8'd0;
    else if (r > 127)
      return 8'd127;
    else
      return r[7:0];
  endfunction

  logic                     vld_p1;
  logic                     first_p1;
  logic                     last_p1;
  logic signed [DATA_W:0]   pix_s;
  logic signed [PROD_W-1:0] prod_p1;
  acc_t                     acc_p1;
  acc_t                     acc_next;

  // p0 -> p1: tap flags follow the address by one cycle to meet the RAM data
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      result   <= '0;
    end else begin
      vld_p1   <= vld_p0;
      first_p1 <= vld_p0 & first_p0;
      last_p1  <= vld_p0 & last_p0;
      if (vld_p1 && last_p1)
        result <= relu_sat(acc_next);
    end
  end

  assign pix_s   = $signed({1'b0, pixel});
  assign prod_p1 = pix_s * weight;

  // The first tap overwrites the accumulator, so no clear cycle is needed.
  always_comb begin
    acc_next = first_p1 ? acc_t'(prod_p1) : acc_p1 + acc_t'(prod_p1);
  end

  always_ff @(posedge clk) begin
    if (vld_p1)
      acc_p1 <= acc_next;
  end

endmodule

// File: rtl/conv_layer_engine.sv
// Strided single-input-channel 2-D convolution layer: walks oc/oy/ox/ky/kx with
// running address adders and writes one requantised byte per output pixel.
module conv_layer_engine #(
  parameter int IMG_W     = 100,
  parameter int K         = 5,
  parameter int STRIDE    = 3,
  parameter int N_OC      = 16,
  parameter int SHIFT     = 8,
  parameter int ADDR_SIZE = 19
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  output logic      done,
  conv_mem_if.master mem
);

  import cnn_pkg::*;

  localparam int OW    = (IMG_W - K) / STRIDE + 1;
  localparam int OH    = OW;
  localparam int TOTAL = N_OC * OH * OW;
  localparam int KW    = $clog2(K + 1);
  localparam int OWW   = $clog2(OW + 1);
  localparam int OCW   = $clog2(N_OC + 1);

  localparam logic [ADDR_SIZE-1:0] ROW_STEP  = ADDR_SIZE'(STRIDE * IMG_W);
  localparam logic [ADDR_SIZE-1:0] COL_STEP  = ADDR_SIZE'(STRIDE);
  localparam logic [ADDR_SIZE-1:0] OC_STEP   = ADDR_SIZE'(K * K);
  localparam logic [ADDR_SIZE-1:0] LINE_STEP = ADDR_SIZE'(IMG_W);
  localparam logic [ADDR_SIZE-1:0] LAST_PIX  = ADDR_SIZE'(TOTAL - 1);

  conv_state_t          state;
  logic [KW-1:0]        kx, ky;
  logic [OWW-1:0]       ox, oy;
  logic [OCW-1:0]       oc;
  logic [ADDR_SIZE-1:0] row_base, col_base, row_ptr, w_base;
  logic [ADDR_SIZE-1:0] in_addr_r, w_addr_r, out_addr_r;
  logic                 out_we_r, done_r;
  logic                 vld_p0, first_p0, last_p0;
  logic                 last_tap;
  logic [7:0]           result;

  assign last_tap = (kx == KW'(K - 1)) && (ky == KW'(K - 1));
  assign vld_p0   = (state == MAC);
  assign first_p0 = (kx == '0) && (ky == '0);
  assign last_p0  = last_tap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      kx         <= '0;
      ky         <= '0;
      ox         <= '0;
      oy         <= '0;
      oc         <= '0;
      row_base   <= '0;
      col_base   <= '0;
      row_ptr    <= '0;
      w_base     <= '0;
      in_addr_r  <= '0;
      w_addr_r   <= '0;
      out_addr_r <= '0;
      out_we_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      out_we_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start)
            state <= MAC;
        end
        MAC: begin
          w_addr_r <= w_addr_r + ADDR_SIZE'(1);
          if (kx != KW'(K - 1)) begin
            kx        <= kx + KW'(1);
            in_addr_r <= in_addr_r + ADDR_SIZE'(1);
          end else if (ky != KW'(K - 1)) begin
            kx        <= '0;
            ky        <= ky + KW'(1);
            row_ptr   <= row_ptr + LINE_STEP;
            in_addr_r <= row_ptr + LINE_STEP;
          end else begin
            // Last tap issued: step to the next output pixel while the pipe drains.
            kx    <= '0;
            ky    <= '0;
            state <= DRAIN;
            if (ox != OWW'(OW - 1)) begin
              ox       <= ox + OWW'(1);
              col_base <= col_base + COL_STEP;
            end else begin
              ox       <= '0;
              col_base <= '0;
              if (oy != OWW'(OH - 1)) begin
                oy       <= oy + OWW'(1);
                row_base <= row_base + ROW_STEP;
              end else begin
                oy       <= '0;
                row_base <= '0;
                if (oc != OCW'(N_OC - 1)) begin
                  oc     <= oc + OCW'(1);
                  w_base <= w_base + OC_STEP;
                end else begin
                  oc     <= '0;
                  w_base <= '0;
                end
              end
            end
          end
        end
        DRAIN: begin
          state    <= WRITE;
          out_we_r <= 1'b1;
        end
        WRITE: begin
          if (out_addr_r == LAST_PIX) begin
            state      <= DONE;
            done_r     <= 1'b1;
            out_addr_r <= '0;
            in_addr_r  <= '0;
            w_addr_r   <= '0;
            row_ptr    <= '0;
          end else begin
            state      <= MAC;
            out_addr_r <= out_addr_r + ADDR_SIZE'(1);
            in_addr_r  <= row_base + col_base;
            row_ptr    <= row_base + col_base;
            w_addr_r   <= w_base;
          end
        end
        DONE: begin
          if (!start) begin
            state  <= IDLE;
            done_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_mac #(
    .SHIFT  (SHIFT),
    .DATA_W (8),
    .COEF_W (8)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .vld_p0   (vld_p0),
    .first_p0 (first_p0),
    .last_p0  (last_p0),
    .pixel    (mem.in_data),
    .weight   (mem.w_data),
    .result   (result)
  );

  assign mem.in_addr  = in_addr_r;
  assign mem.w_addr   = w_addr_r;
  assign mem.out_addr = out_addr_r;
  assign mem.out_data = result;
  assign mem.out_we   = out_we_r;
  assign done         = done_r;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine on a 7x7 image, 3x3 kernel, stride 2, 2 output channels.
module tb_conv_layer_engine;

  logic clk;
  logic reset;
  logic start;
  logic done0, done1;

  conv_mem_if bus0 ();
  conv_mem_if bus1 ();

  conv_layer_engine #(
    .IMG_W(7), .K(3), .STRIDE(2), .N_OC(2), .SHIFT(0), .ADDR_SIZE(19)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .done(done0), .mem(bus0)
  );

  conv_layer_engine #(
    .IMG_W(7), .K(3), .STRIDE(2), .N_OC(2), .SHIFT(12), .ADDR_SIZE(19)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .done(done1), .mem(bus1)
  );

  logic [7:0] img [0:63];
  logic [7:0] wt  [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus0.in_data <= img[bus0.in_addr[5:0]];
    bus0.w_data  <= wt[bus0.w_addr[5:0]];
    bus1.in_data <= img[bus1.in_addr[5:0]];
    bus1.w_data  <= wt[bus1.w_addr[5:0]];
  end

  typedef struct {
    string      name;
    logic [7:0] pix;
    logic [7:0] w;
    int         exp0;
    int         exp12;
  } vec_t;

  vec_t vecs [6];
  int   ntests = 0;
  int   nfail  = 0;
  int   nwr, first_we, done_cyc;
  int   wa [32];
  int   wd [32];
  int   wd1 [32];
  int   exp_imp [18];

  task automatic chk(input string nm, input int act, input int exp_v);
    ntests++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic fill(input logic [7:0] p, input logic [7:0] w);
    for (int i = 0; i < 64; i++) begin
      img[i] = p;
      wt[i]  = w;
    end
  endtask

  // One full layer; hold keeps start high past done to probe the handshake.
  task automatic run_layer(input string tag, input bit hold);
    nwr = 0; first_we = 0; done_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 3 && !hold) start = 1'b0;
      if (bus0.out_we) begin
        if (nwr < 32) begin
          wa[nwr]  = int'(bus0.out_addr);
          wd[nwr]  = int'(bus0.out_data);
          wd1[nwr] = int'(bus1.out_data);
        end
        if (first_we == 0) first_we = k;
        nwr++;
      end
      if (done0) begin
        done_cyc = k;
        break;
      end
    end
    chk({tag, " done_latency"}, done_cyc, 199);
    chk({tag, " first_we_cycle"}, first_we, 11);
    chk({tag, " write_count"}, nwr, 18);
    if (hold) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk({tag, " done_held"}, int'(done0), 1);
        chk({tag, " no_write_in_done"}, int'(bus0.out_we), 0);
      end
      start = 1'b0;
    end
    @(negedge clk);
    chk({tag, " done_drop"}, int'(done0), 0);
  endtask

  task automatic chk_writes(input string tag, input int exp0, input int exp12);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), wa[i], i);
      chk($sformatf("%s data[%0d]", tag, i), wd[i], exp0);
      chk($sformatf("%s data_sh12[%0d]", tag, i), wd1[i], exp12);
    end
  endtask

  initial begin
    vecs[0] = '{"ones",     8'd1,   8'd1,   9,   0};
    vecs[1] = '{"relu",     8'd50,  8'hFF,  0,   0};
    vecs[2] = '{"sat",      8'd255, 8'h7F,  127, 71};
    vecs[3] = '{"below127", 8'd14,  8'd1,   126, 0};
    vecs[4] = '{"above127", 8'd15,  8'd1,   127, 0};
    vecs[5] = '{"shift_mid", 8'd100, 8'd10, 127, 2};

    reset = 1'b0;
    start = 1'b0;
    fill(8'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("rst done", int'(done0), 0);
    chk("rst out_we", int'(bus0.out_we), 0);
    chk("rst out_data", int'(bus0.out_data), 0);
    chk("rst out_addr", int'(bus0.out_addr), 0);
    chk("rst in_addr", int'(bus0.in_addr), 0);
    chk("rst w_addr", int'(bus0.w_addr), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pix, vecs[v].w);
      run_layer(vecs[v].name, 1'b0);
      chk_writes(vecs[v].name, vecs[v].exp0, vecs[v].exp12);
    end

    // Single impulse: only output 0 sees pixel (2,2) through tap (2,2).
    fill(8'd0, 8'd0);
    img[2*7+2] = 8'd10;
    wt[8]      = 8'd3;
    run_layer("impulse", 1'b0);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("impulse addr[%0d]", i), wa[i], i);
      chk($sformatf("impulse data[%0d]", i), wd[i], (i == 0) ? 30 : 0);
    end

    // Two impulses across both channels exercise row, column and channel stepping.
    img[4*7+6] = 8'd7;
    wt[9+2]    = 8'd2;
    for (int i = 0; i < 18; i++) exp_imp[i] = 0;
    exp_imp[0]  = 30;
    exp_imp[5]  = 21;
    exp_imp[12] = 20;
    exp_imp[17] = 14;
    run_layer("impulse2", 1'b0);
    for (int i = 0; i < 18; i++)
      chk($sformatf("impulse2 data[%0d]", i), wd[i], exp_imp[i]);

    // Reset during the sixth pixel's MAC, then a clean restart.
    fill(8'd1, 8'd1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 58; k++) begin
      @(negedge clk);
      if (k == 3) start = 1'b0;
    end
    chk("midrun out_addr_before", int'(bus0.out_addr), 5);
    reset = 1'b0;
    @(negedge clk);
    chk("midrun out_we", int'(bus0.out_we), 0);
    chk("midrun done", int'(done0), 0);
    chk("midrun out_addr", int'(bus0.out_addr), 0);
    chk("midrun in_addr", int'(bus0.in_addr), 0);
    chk("midrun w_addr", int'(bus0.w_addr), 0);
    reset = 1'b1;
    fill(8'd2, 8'd3);
    run_layer("after_reset", 1'b0);
    chk_writes("after_reset", 54, 0);

    // Start held through done, then a second identical run.
    fill(8'd255, 8'h7F);
    run_layer("hold1", 1'b1);
    chk_writes("hold1", 127, 71);
    run_layer("hold2", 1'b0);
    chk_writes("hold2", 127, 71);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
